// File: rtl/ram_reader_pkg.sv
// Shared definitions for the RAM burst reader.
// Contents: default address/data widths and the reader FSM state encoding.
package ram_reader_pkg;

    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: reads a contiguous block from a combinational-read RAM
// and streams the words out over a valid/ready handshake. Never writes RAM.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 one-cycle burst request, sampled only in IDLE
//   base_addr, len        first address and word count (0..2^ADDR_W)
//   ram_address, ram_load RAM address (held outside READ), write enable (0)
//   ram_out               combinational RAM read data
//   out_data/valid/last   beat stream to the consumer
//   out_ready             consumer accepts the beat
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse on burst completion
//   sum                   (RAM_BURST_READER_SUM_EN only) wrapping sum of beats
//
// Optional feature macro: RAM_BURST_READER_SUM_EN
module ram_burst_reader
    import ram_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef RAM_BURST_READER_SUM_EN
    ,
    output logic [DATA_W-1:0] sum
`endif
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    state_e              state_q, state_d;
    // cur_addr doubles as the registered RAM address so it is valid for the whole READ cycle
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef RAM_BURST_READER_SUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef RAM_BURST_READER_SUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef RAM_BURST_READER_SUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
`ifdef RAM_BURST_READER_SUM_EN
        sum_d       = sum_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef RAM_BURST_READER_SUM_EN
                    sum_d = '0;
`endif
                    if (len != '0) begin
                        cur_addr_d  = base_addr;
                        remaining_d = len;
                        state_d     = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                out_data_d  = ram_out;
                out_valid_d = 1'b1;
                out_last_d  = (remaining_q == LEN_W'(1));
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    remaining_d = remaining_q - LEN_W'(1);
`ifdef RAM_BURST_READER_SUM_EN
                    sum_d       = sum_q + out_data_q;
`endif
                    if (out_last_q) begin
                        out_last_d = 1'b0;
                        state_d    = DONE;
                    end else begin
                        // natural wrap modulo 2^ADDR_W
                        cur_addr_d = cur_addr_q + ADDR_W'(1);
                        state_d    = READ;
                    end
                end
            end
            DONE: begin
                out_last_d = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags registered alongside the state they describe
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign ram_address = cur_addr_q;
    assign ram_load    = 1'b0;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign done        = done_q;
`ifdef RAM_BURST_READER_SUM_EN
    assign sum         = sum_q;
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader (RAM8, 16-bit words).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ram_burst_reader;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic [AW-1:0] ram_address;
    logic          ram_load;
    logic [DW-1:0] ram_out;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
`ifdef RAM_BURST_READER_SUM_EN
    logic [DW-1:0] sum;
`endif

    logic [DW-1:0] mem [8];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    assign ram_out = mem[ram_address];

    ram_burst_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .ram_address(ram_address),
        .ram_load   (ram_load),
        .ram_out    (ram_out),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
`ifdef RAM_BURST_READER_SUM_EN
        ,
        .sum        (sum)
`endif
    );

    typedef struct {
        logic [2:0]  base;
        logic [3:0]  len;
        int          pat;        // 0 fixed words, 1 one-hot, 2 keep current contents
        bit          rnd;        // random out_ready
        int          stall_beat; // beat index that sees out_ready low
        int          stall_n;    // number of low cycles
        int          ign_beat;   // beat index during which a stray start is pulsed
        int          rst_beat;   // beat index during whose HOLD reset is applied
        logic [15:0] exp_first;
        logic [15:0] exp_lastw;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ram_address", 32'(ram_address), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_ram_load", 32'(ram_load), 0);
`ifdef RAM_BURST_READER_SUM_EN
        check("rst_sum", 32'(sum), 0);
`endif
    endtask

    task automatic load_mem(input int pat);
        if (pat == 0) begin
            mem[0] = 16'h8285; mem[1] = 16'h3039; mem[2] = 16'h0000; mem[3] = 16'h0001;
            mem[4] = 16'h8000; mem[5] = 16'hFFFF; mem[6] = 16'h7FFF; mem[7] = 16'h1234;
        end else if (pat == 1) begin
            for (int i = 0; i < 8; i++) mem[i] = 16'(1 << i);
        end
    endtask

    // Runs one burst from a falling edge; model: beats are mem[(base+i) mod 8], i < len.
    task automatic run_burst(input vec_t v);
        logic [15:0] exp_q[$];
        logic [15:0] model_sum;
        logic [15:0] held_data;
        logic [15:0] first_w;
        logic [15:0] last_w;
        logic [2:0]  a;
        bit          held;
        bit          did_rst;
        bit          r;
        int          cyc;
        int          beat;
        int          ndone;
        int          stall_cnt;

        model_sum = '0;
        first_w   = '0;
        last_w    = '0;
        held_data = '0;
        held      = 1'b0;
        did_rst   = 1'b0;
        beat      = 0;
        ndone     = 0;
        stall_cnt = 0;
        for (int i = 0; i < int'(v.len); i++) begin
            a = v.base + 3'(i);
            exp_q.push_back(mem[a]);
            model_sum = model_sum + mem[a];
        end

        start     = 1'b1;
        base_addr = v.base;
        len       = v.len;
        out_ready = 1'b1;
        @(negedge clk);
        cyc = 1;

        forever begin
            start = 1'b0;
            if (cyc == 1) check("busy_after_start", 32'(busy), 1);
            if (cyc == 2 && v.len != 0) check("first_beat_latency", 32'(out_valid), 1);
            check("ram_load", 32'(ram_load), 0);
            if (held) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_data", 32'(out_data), 32'(held_data));
                held = 1'b0;
            end
            if (busy && !out_valid && !done)
                check("ram_address", 32'(ram_address), 32'(3'(v.base + 3'(beat))));
            if (done) begin
                ndone++;
                check("done_all_beats", 32'(beat), 32'(v.len));
                check("done_valid_low", 32'(out_valid), 0);
                check("done_last_low", 32'(out_last), 0);
`ifdef RAM_BURST_READER_SUM_EN
                check("sum", 32'(sum), 32'(model_sum));
`endif
            end
            if (ndone > 0 && !done) begin
                check("idle_after_done", 32'(busy), 0);
                break;
            end
            if (out_valid && beat == v.rst_beat) begin
                rst_n = 1'b0;
                @(negedge clk);
                check_reset_outputs();
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("no_done_after_rst", 32'(done), 0);
                    check("idle_after_rst", 32'(busy), 0);
                end
                did_rst = 1'b1;
                break;
            end
            if (out_valid && beat == v.ign_beat) begin
                start     = 1'b1;
                base_addr = 3'd3;
                len       = 4'd5;
            end

            if (v.rnd) r = ($urandom_range(0, 2) != 0);
            else if (out_valid && beat == v.stall_beat && stall_cnt < v.stall_n) begin
                r = 1'b0;
                stall_cnt++;
            end else r = 1'b1;
            out_ready = r;

            if (out_valid && r) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    check("beat_data", 32'(out_data), 32'(exp_q[0]));
                    check("beat_last", 32'(out_last), 32'(exp_q.size() == 1));
                    if (beat == 0) first_w = out_data;
                    last_w = out_data;
                    void'(exp_q.pop_front());
                end
                beat++;
            end else if (out_valid) begin
                held      = 1'b1;
                held_data = out_data;
            end

            @(negedge clk);
            cyc++;
            if (cyc > 300) begin
                check("timeout", 0, 1);
                break;
            end
        end

        start = 1'b0;
        if (!did_rst) begin
            check("done_count", 32'(ndone), 1);
            check("beats_left", 32'(exp_q.size()), 0);
            if (v.len != 0) begin
                check("first_word", 32'(first_w), 32'(v.exp_first));
                check("last_word", 32'(last_w), 32'(v.exp_lastw));
            end
        end
    endtask

    vec_t tbl [9];
    vec_t rv;

    initial begin
        //         base  len   pat rnd stall_beat/n ign rst  first     last
        tbl[0] = '{3'd0, 4'd4, 0, 0, -1, 0, -1, -1, 16'h8285, 16'h0001};
        tbl[1] = '{3'd6, 4'd8, 1, 0, -1, 0, -1, -1, 16'h0040, 16'h0020};
        tbl[2] = '{3'd0, 4'd4, 0, 0,  1, 5, -1, -1, 16'h8285, 16'h0001};
        tbl[3] = '{3'd0, 4'd0, 0, 0, -1, 0, -1, -1, 16'h0000, 16'h0000};
        tbl[4] = '{3'd0, 4'd4, 0, 0, -1, 0,  1, -1, 16'h8285, 16'h0001};
        tbl[5] = '{3'd0, 4'd4, 0, 0, -1, 0, -1,  1, 16'h8285, 16'h0001};
        tbl[6] = '{3'd7, 4'd1, 1, 0, -1, 0, -1, -1, 16'h0080, 16'h0080};
        tbl[7] = '{3'd5, 4'd3, 1, 1, -1, 0, -1, -1, 16'h0020, 16'h0080};
        tbl[8] = '{3'd4, 4'd3, 0, 0, -1, 0, -1, -1, 16'h8000, 16'h7FFF};

        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        out_ready = 1'b0;
        load_mem(0);
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        for (int i = 0; i < 9; i++) begin
            load_mem(tbl[i].pat);
            run_burst(tbl[i]);
        end

        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
            rv.base       = 3'($urandom_range(0, 7));
            rv.len        = 4'($urandom_range(0, 8));
            rv.pat        = 2;
            rv.rnd        = 1'b1;
            rv.stall_beat = -1;
            rv.stall_n    = 0;
            rv.ign_beat   = -1;
            rv.rst_beat   = -1;
            rv.exp_first  = mem[rv.base];
            rv.exp_lastw  = mem[3'(rv.base + 3'(rv.len) - 3'd1)];
            run_burst(rv);
            if (($urandom & 32'h3) == 0) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
